// File: rtl/nvic_nest_ctrl.sv
// nvic_nest_ctrl: nested priority interrupt controller.
//   NUM_IRQ request channels (channel k = i_irq[k-1], priority k, higher wins),
//   each in edge or level mode. Taken interrupts are pushed on a priority
//   stack of NEST_DEPTH entries; only requests that outrank the stack top are
//   presented to the core.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_memAddr          register select: 0 enable, 1 flags, 2 mode, 3 status
//   i_memDataIn        write data (channel k at bit k)
//   i_memWrEn          write strobe
//   o_memDataOut       combinational read of the selected register
//   i_irq              request lines
//   i_intAck           core takes the presented interrupt
//   i_intRet           core returns from the current in-service interrupt
//   o_intCode          presented interrupt code, 0 = none
//   o_intEn            an interrupt is presented
module nvic_nest_ctrl #(
  parameter int unsigned NUM_IRQ    = 11,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_memAddr,
  input  logic [DATA_W-1:0] i_memDataIn,
  input  logic              i_memWrEn,
  output logic [DATA_W-1:0] o_memDataOut,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic              i_intAck,
  input  logic              i_intRet,
  output logic [CODE_W-1:0] o_intCode,
  output logic              o_intEn
);

  localparam int unsigned DEPTH_W = $clog2(NEST_DEPTH + 1);

  typedef enum logic [1:0] {
    REG_ENABLE = 2'd0,
    REG_FLAGS  = 2'd1,
    REG_MODE   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  reg_sel_e sel;

  logic [NUM_IRQ:1]     en_q;
  logic [NUM_IRQ:1]     flag_q;
  logic [NUM_IRQ:1]     mode_q;
  logic [NUM_IRQ:1]     irq_q;
  logic [CODE_W-1:0]    stack_q [NEST_DEPTH];
  logic [DEPTH_W-1:0]   depth_q;

  logic [CODE_W-1:0]    top;
  logic [CODE_W-1:0]    cand;
  logic [CODE_W-1:0]    code;
  logic                 take;
  logic                 pop;
  logic                 wr_enable;
  logic                 wr_flags;
  logic                 wr_mode;
  logic                 unused_data;

  assign sel         = reg_sel_e'(i_memAddr);
  assign wr_enable   = i_memWrEn && (sel == REG_ENABLE);
  assign wr_flags    = i_memWrEn && (sel == REG_FLAGS);
  assign wr_mode     = i_memWrEn && (sel == REG_MODE);
  // Bit 0 and bits above NUM_IRQ carry no channel.
  assign unused_data = ^i_memDataIn;

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
      if (32'(depth_q) == i + 1) top = stack_q[i];
    end
  end

  always_comb begin
    cand = '0;
    for (int unsigned k = 1; k <= NUM_IRQ; k++) begin
      if (en_q[k] && flag_q[k]) cand = CODE_W'(k);
    end
  end

  assign code      = ((cand > top) && (32'(depth_q) < NEST_DEPTH)) ? cand : '0;
  assign o_intCode = code;
  assign o_intEn   = (code != '0);
  assign take      = i_intAck && o_intEn;
  assign pop       = i_intRet && (depth_q != '0);

  always_comb begin
    o_memDataOut = '0;
    case (sel)
      REG_ENABLE: o_memDataOut[NUM_IRQ:1] = en_q;
      REG_FLAGS:  o_memDataOut[NUM_IRQ:1] = flag_q;
      REG_MODE:   o_memDataOut[NUM_IRQ:1] = mode_q;
      REG_STATUS: begin
        o_memDataOut[CODE_W-1:0]       = top;
        o_memDataOut[CODE_W +: DEPTH_W] = depth_q;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q    <= '0;
      flag_q  <= '0;
      mode_q  <= '0;
      irq_q   <= '0;
      depth_q <= '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      irq_q <= i_irq;
      if (wr_enable) en_q   <= i_memDataIn[NUM_IRQ:1];
      if (wr_mode)   mode_q <= i_memDataIn[NUM_IRQ:1];

      for (int unsigned k = 1; k <= NUM_IRQ; k++) begin
        if (mode_q[k]) begin
          // A new rising edge beats any clear arriving in the same cycle.
          flag_q[k] <= (i_irq[k-1] && !irq_q[k]) ||
                       (flag_q[k] && !((wr_flags && i_memDataIn[k]) ||
                                       (take && (code == CODE_W'(k)))));
        end else begin
          flag_q[k] <= i_irq[k-1];
        end
      end

      // Simultaneous ack and ret: the popped slot is reused for the new code.
      if (take) begin
        for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
          if (pop ? (32'(depth_q) == i + 1) : (32'(depth_q) == i))
            stack_q[i] <= code;
        end
      end

      if (take && !pop)      depth_q <= depth_q + DEPTH_W'(1);
      else if (pop && !take) depth_q <= depth_q - DEPTH_W'(1);
    end
  end

endmodule

// File: tb/tb_nvic_nest_ctrl.sv
// Directed bench for nvic_nest_ctrl with NEST_DEPTH=2, other parameters default.
module tb_nvic_nest_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] din;
  logic        we;
  logic [15:0] dout;
  logic [10:0] irq;
  logic        ack;
  logic        ret;
  logic [3:0]  code;
  logic        int_en;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  nvic_nest_ctrl #(
    .NUM_IRQ(11),
    .DATA_W(16),
    .CODE_W(4),
    .NEST_DEPTH(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_memAddr(addr),
    .i_memDataIn(din),
    .i_memWrEn(we),
    .o_memDataOut(dout),
    .i_irq(irq),
    .i_intAck(ack),
    .i_intRet(ret),
    .o_intCode(code),
    .o_intEn(int_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic chk_int(input string tag, input logic [3:0] exp_code);
    check({tag, "_code"}, 16'(code), 16'(exp_code));
    check({tag, "_en"}, 16'(int_en), 16'(exp_code != 4'd0));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_ret();
    ret = 1'b1;
    tick();
    ret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; din = '0; we = 1'b0; irq = '0; ack = 1'b0; ret = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rd(2'd0, 16'h0000, "rst_enable");
    rd(2'd1, 16'h0000, "rst_flags");
    rd(2'd2, 16'h0000, "rst_mode");
    rd(2'd3, 16'h0000, "rst_status");
    chk_int("rst", 4'd0);

    // Level channel 5 pulsed while disabled: flag follows, nothing presented
    irq[4] = 1'b1;
    tick();
    rd(2'd1, 16'h0020, "lvl5_flag");
    chk_int("lvl5_disabled", 4'd0);
    irq[4] = 1'b0;
    tick();
    rd(2'd1, 16'h0000, "lvl5_drop");

    // Edge mode on 3, 5, 7; enable 3 and 7; pulse 3 and 7 together
    wr(2'd2, 16'h00A8);
    rd(2'd2, 16'h00A8, "mode_rb");
    wr(2'd0, 16'hFFFF & 16'h0088);
    rd(2'd0, 16'h0088, "enable_rb");
    irq = 11'h044;
    tick();
    irq = '0;
    chk_int("edge_3_7", 4'd7);
    rd(2'd1, 16'h0088, "edge_flags");

    do_ack();
    rd(2'd3, 16'h0017, "ack7_status");
    rd(2'd1, 16'h0008, "ack7_flags");
    chk_int("ack7_no_preempt", 4'd0);

    do_ret();
    chk_int("ret7", 4'd3);
    rd(2'd3, 16'h0000, "ret7_status");

    // Nesting: take 3, then level channel 9 pre-empts
    do_ack();
    rd(2'd3, 16'h0013, "ack3_status");
    chk_int("ack3", 4'd0);
    wr(2'd0, 16'h0288);
    irq[8] = 1'b1;
    tick();
    chk_int("irq9", 4'd9);
    do_ack();
    rd(2'd3, 16'h0029, "ack9_status");
    chk_int("ack9", 4'd0);

    // Full stack: channel 11 waits
    wr(2'd0, 16'h0A88);
    irq[10] = 1'b1;
    tick();
    rd(2'd1, 16'h0A00, "full_flags");
    chk_int("full_hold", 4'd0);
    do_ack();
    rd(2'd3, 16'h0029, "ack_ignored");

    do_ret();
    chk_int("after_ret", 4'd11);
    rd(2'd3, 16'h0013, "after_ret_status");

    // Ack and ret together: 3 popped, 11 pushed in its place
    ack = 1'b1;
    ret = 1'b1;
    tick();
    ack = 1'b0;
    ret = 1'b0;
    rd(2'd3, 16'h001B, "ackret_status");
    chk_int("ackret", 4'd0);

    do_ret();
    rd(2'd3, 16'h0000, "ret_to_zero");
    do_ret();
    rd(2'd3, 16'h0000, "ret_underflow");
    chk_int("ret_underflow", 4'd11);

    irq[10] = 1'b0;
    irq[8]  = 1'b0;
    tick();
    rd(2'd1, 16'h0000, "levels_drop");
    chk_int("levels_drop", 4'd0);

    // W1C on edge channel 5 coincident with a new rising edge: set wins
    irq[4] = 1'b1;
    wr(2'd1, 16'h0020);
    rd(2'd1, 16'h0020, "w1c_vs_edge");
    wr(2'd1, 16'h0020);
    rd(2'd1, 16'h0000, "w1c_clear");
    irq[4] = 1'b0;

    // Level channel 2 held through ack
    wr(2'd0, 16'h0A8C);
    irq[1] = 1'b1;
    tick();
    chk_int("lvl2", 4'd2);
    do_ack();
    rd(2'd1, 16'h0004, "lvl2_held");
    rd(2'd3, 16'h0012, "lvl2_status");
    irq[1] = 1'b0;
    tick();
    rd(2'd1, 16'h0000, "lvl2_drop");

    // Reach depth 2, then reset mid-nest
    irq[6] = 1'b1;
    tick();
    chk_int("edge7_over2", 4'd7);
    do_ack();
    rd(2'd3, 16'h0027, "depth2_status");
    irq = '0;
    rst = 1'b1;
    ack = 1'b1;
    tick();
    rst = 1'b0;
    ack = 1'b0;
    rd(2'd3, 16'h0000, "midrst_status");
    rd(2'd0, 16'h0000, "midrst_enable");
    rd(2'd1, 16'h0000, "midrst_flags");
    rd(2'd2, 16'h0000, "midrst_mode");
    chk_int("midrst", 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nvic_nest_ctrl.md
Name: nvic_nest_ctrl

Overview:
- Parametrised successor to the fixed 11-channel interrupt controller.
- Prioritises NUM_IRQ interrupt request lines, with a per-channel edge or level mode.
- Tracks nested in-service interrupts on a hardware priority stack and presents only requests that can pre-empt the current one.
- Sits between the memory-map decoder and the core's interrupt port; the core acknowledges taken interrupts and signals returns.

Parameters:
- NUM_IRQ, 11: request channels 1..NUM_IRQ; channel k has priority k (higher wins); legal range 1..DATA_W-1.
- DATA_W, 16: memory-map data width.
- CODE_W, 4: interrupt code width; 2**CODE_W > NUM_IRQ is required.
- NEST_DEPTH, 4: maximum in-service nesting depth (stack entries), at least 1.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_memAddr  in  2  register select: 0 enable, 1 flags, 2 mode, 3 status.
- i_memDataIn  in  DATA_W  write data; channel k maps to bit k, bit 0 unused.
- i_memWrEn  in  1  write strobe for the selected register.
- o_memDataOut  out  DATA_W  combinational read of the selected register.
- i_irq  in  NUM_IRQ  request lines; i_irq[k-1] is channel k.
- i_intAck  in  1  core has taken the presented interrupt this cycle.
- i_intRet  in  1  core has returned from the current in-service interrupt.
- o_intCode  out  CODE_W  code of the presented interrupt; 0 means none.
- o_intEn  out  1  an interrupt is presented.

Behaviour:
- Reset (i_rst high at a clock edge): enable, flags, mode, edge history and stack all clear; depth 0; o_intCode=0, o_intEn=0, o_memDataOut reads 0 for addrs 0-2. Reset overrides every concurrent event.
- Mode (addr 2): bit k=1 selects edge mode for channel k, 0 selects level mode. Writable only through memory writes; read back at the same bit positions.
- Enable (addr 0): plain read/write of bits 1..NUM_IRQ. All other bits read 0 and are ignored on write.
- Level channel:
  - Flag k equals the registered i_irq[k-1], one cycle late.
  - Memory writes and ack do not alter it.
- Edge channel:
  - Flag k sets the cycle after a 0->1 transition of i_irq[k-1], using a registered prior value.
  - Flag k clears on a write to addr 1 with bit k=1 (write-1-to-clear), or on ack of code k.
  - Set wins over any clear in the same cycle.
- Flags read (addr 1): current flags at bits 1..NUM_IRQ.
- Candidate: the highest k with enable[k] and flag[k] both set; 0 if none.
- Top: the code at the top of the stack; 0 when the stack is empty.
- Present rule: o_intCode = candidate if candidate > top and depth < NEST_DEPTH, else 0. o_intEn = (o_intCode != 0). Both are combinational from registered state.
- Ack (i_intAck=1 and o_intEn=1):
  - Push o_intCode and increment depth.
  - If channel o_intCode is in edge mode, clear its flag.
  - i_intAck with o_intEn=0 is ignored.
- Ret (i_intRet=1 and depth>0): pop and decrement depth. i_intRet with depth=0 is ignored; no underflow.
- Ack and Ret in the same cycle:
  - Pop first, then push the code that was presented before the pop; depth is unchanged.
  - The pushed code replaces the old top.
- Status (addr 3, read-only):
  - Bits [CODE_W-1:0] hold top.
  - Bits [CODE_W+clog2(NEST_DEPTH+1)-1:CODE_W] hold depth.
  - Remaining bits read 0; writes are ignored.
- Latency: an edge on i_irq at cycle t (sampled) gives flag set at t+1 and o_intEn at t+1. Ack at t gives the updated top and o_intCode at t+1.
- Memory writes and hardware events in the same cycle both take effect, subject to the set-wins rule. An enable write takes effect for presentation from the next cycle.
- Full stack: no presentation at all. Flags keep accumulating and are presented after a Ret.

Test Plan:
- Reset, then read all four addrs -> all 0; o_intEn=0. Pulse i_irq[4] (channel 5) with enable=0 -> flag5 set, o_intEn stays 0.
- Edge mode on channels 3 and 7, enable both, pulse both in the same cycle -> next cycle o_intCode=7. Ack -> status shows top=7, depth=1, flag7 clear, o_intCode=0 (3<7). Ret -> o_intCode=3.
- Nesting: ack code 3, then raise channel 9 -> o_intCode=9. Ack -> depth=2, top=9. Ret twice -> depth 0. A third Ret -> ignored, depth stays 0.
- NEST_DEPTH=2: ack two interrupts, raise channel 11 -> o_intEn=0 until Ret, then o_intCode=11.
- Write-1-to-clear on flag 5 in the same cycle as a new rising edge on channel 5 -> flag5 remains set. The next write to clear it succeeds.
- Level channel 2 held high through ack -> flag2 remains 1 and status top=2. Drop i_irq[1] -> flag2 clears one cycle later. Reset asserted mid-nest at depth 2 -> depth 0, all outputs 0.
